// File: rtl/xoodyak_hash_host.sv
// Host-side initiator for the XOODYAK hash core: buffers a message,
// streams it into the core and assembles the 32-byte digest.
module xoodyak_hash_host #(
   parameter int MAX_LEN = 256,
   parameter int TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         core_start,
   output logic [7:0]   core_msg,
   output logic [11:0]  core_msg_len,
   input  logic [7:0]   core_hash,
   input  logic         core_valid,
   input  logic         core_busy,
   output logic [255:0] digest,
   output logic         digest_valid,
   input  logic         digest_ack,
   output logic         err
);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [11:0] LAST_IDX = 12'(MAX_LEN - 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {LOAD, START, FEED, COLLECT, DONE} state_t;

   state_t         state_q, state_d;
   logic [11:0]    wr_ptr_q, wr_ptr_d;
   logic [11:0]    rd_ptr_q, rd_ptr_d;
   logic [11:0]    len_q, len_d;
   logic [5:0]     hcnt_q, hcnt_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           err_q, err_d;
   logic           digest_valid_q, digest_valid_d;
   logic [7:0]     msg_q, msg_d;
   logic [255:0]   digest_q, digest_d;
   logic [7:0]     mem_q [2**AW];
   logic           mem_we;
   logic           progress;

   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      len_d          = len_q;
      hcnt_d         = hcnt_q;
      tmo_d          = tmo_q;
      err_d          = err_q;
      digest_d       = digest_q;
      digest_valid_d = digest_valid_q;
      mem_we         = 1'b0;
      progress       = 1'b0;
      msg_d          = 8'h00;
      unique case (state_q)
         LOAD: begin
            if (in_valid) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 12'd1;
               if (wr_ptr_q == 12'd0) err_d = 1'b0;
               if (in_last) begin
                  len_d    = wr_ptr_q + 12'd1;
                  wr_ptr_d = 12'd0;
                  state_d  = START;
               end else if (wr_ptr_q == LAST_IDX) begin
                  err_d    = 1'b1;
                  wr_ptr_d = 12'd0;
               end
            end
         end
         START: begin
            rd_ptr_d = 12'd0;
            hcnt_d   = 6'd0;
            tmo_d    = '0;
            state_d  = FEED;
         end
         FEED, COLLECT: begin
            if (state_q == FEED && !core_busy) begin
               progress = 1'b1;
               if (rd_ptr_q != 12'hfff) rd_ptr_d = rd_ptr_q + 12'd1;
            end
            if (core_valid) begin
               progress = 1'b1;
               digest_d[8*hcnt_q[4:0] +: 8] = core_hash;
               hcnt_d = hcnt_q + 6'd1;
               if (hcnt_q == 6'd31) begin
                  digest_valid_d = 1'b1;
                  state_d        = DONE;
               end else begin
                  state_d = COLLECT;
               end
            end
            // progress in the abort cycle wins over the timeout
            if (progress) begin
               tmo_d = '0;
            end else if (tmo_q == TMO_MAX) begin
               err_d   = 1'b1;
               state_d = LOAD;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DONE: begin
            if (digest_ack) begin
               digest_valid_d = 1'b0;
               hcnt_d         = 6'd0;
               wr_ptr_d       = 12'd0;
               state_d        = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
      // prefetch so core_msg always shows mem[rd_ptr] while feeding
      if (state_d == FEED && rd_ptr_d < len_q)
         msg_d = mem_q[rd_ptr_d[AW-1:0]];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= LOAD;
         wr_ptr_q       <= 12'd0;
         rd_ptr_q       <= 12'd0;
         len_q          <= 12'd0;
         hcnt_q         <= 6'd0;
         tmo_q          <= '0;
         err_q          <= 1'b0;
         digest_valid_q <= 1'b0;
         msg_q          <= 8'h00;
         digest_q       <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         len_q          <= len_d;
         hcnt_q         <= hcnt_d;
         tmo_q          <= tmo_d;
         err_q          <= err_d;
         digest_valid_q <= digest_valid_d;
         msg_q          <= msg_d;
         digest_q       <= digest_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
   end

   assign in_ready     = (state_q == LOAD);
   assign core_start   = (state_q == START);
   assign core_msg     = msg_q;
   assign core_msg_len = len_q;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;
   assign err          = err_q;

endmodule

// File: tb/tb_xoodyak_hash_host.sv
// Randomized bench for xoodyak_hash_host with a behavioural
// core model and per-message expected digest.
module tb_xoodyak_hash_host;
   localparam int ML = 32;
   localparam int TO = 64;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_data = 8'h00;
   logic         in_last = 1'b0;
   logic         core_start;
   logic [7:0]   core_msg;
   logic [11:0]  core_msg_len;
   logic [7:0]   core_hash = 8'h00;
   logic         core_valid = 1'b0;
   logic         core_busy = 1'b1;
   logic [255:0] digest;
   logic         digest_valid;
   logic         digest_ack = 1'b0;
   logic         err;

   int n_checks = 0;
   int n_errors = 0;
   int starts = 0;
   int exp_starts = 0;
   logic [7:0]   msg [ML];
   logic [255:0] exp_dig;

   xoodyak_hash_host #(.MAX_LEN(ML), .TIMEOUT(TO)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .core_start(core_start), .core_msg(core_msg),
      .core_msg_len(core_msg_len), .core_hash(core_hash),
      .core_valid(core_valid), .core_busy(core_busy),
      .digest(digest), .digest_valid(digest_valid),
      .digest_ack(digest_ack), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (core_start === 1'b1) starts <= starts + 1;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rst();
      chk("rst_rdy", in_ready, 1);
      chk("rst_start", core_start, 0);
      chk("rst_msg", core_msg, 0);
      chk("rst_len", core_msg_len, 0);
      chk("rst_dig", digest, 0);
      chk("rst_dv", digest_valid, 0);
      chk("rst_err", err, 0);
   endtask

   task automatic load_bytes(input int n, input bit last);
      for (int i = 0; i < n; i++) begin
         int w;
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         in_valid = 1'b1;
         in_data  = msg[i];
         in_last  = last && (i == n - 1);
         w = 0;
         while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
         chk("rdy_load", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_msg(input int n, input int nfeed, input bit seq_hash,
                          input bit rnd_busy, input int hold,
                          input int abort_at);
      int idx;
      int got;
      int guard;
      logic [7:0] h;
      load_bytes(n, 1'b1);
      exp_starts++;
      chk("start", core_start, 1);
      chk("msg_len", core_msg_len, n[11:0]);
      chk("rdy_start", in_ready, 0);
      @(posedge clk); #1;
      chk("start_once", core_start, 0);
      idx = 0;
      guard = 0;
      while (idx < nfeed && guard < 1000) begin
         core_busy = rnd_busy ? 1'($urandom_range(0, 1)) : 1'b0;
         if (!core_busy) begin
            chk("core_msg", core_msg, (idx < n) ? msg[idx] : 8'h00);
            idx++;
         end
         @(posedge clk); #1;
         guard++;
      end
      core_busy = 1'b1;
      got = 0;
      while (got < 32) begin
         if (abort_at != 0 && got == abort_at) return;
         core_valid = 1'($urandom_range(0, 3) != 0);
         if (core_valid) begin
            h = seq_hash ? 8'(got) : 8'($urandom);
            core_hash = h;
            exp_dig[8*got +: 8] = h;
            got++;
         end
         if (got == 32) chk("dv_early", digest_valid, 0);
         @(posedge clk); #1;
      end
      core_valid = 1'b0;
      chk("dv_set", digest_valid, 1);
      chk("digest", digest, exp_dig);
      in_valid = 1'b1;
      in_data  = 8'h5a;
      in_last  = 1'b1;
      for (int i = 0; i < hold; i++) begin
         core_valid = (i == 0);
         core_hash  = 8'hee;
         @(posedge clk); #1;
      end
      core_valid = 1'b0;
      chk("dv_hold", digest_valid, 1);
      chk("dig_hold", digest, exp_dig);
      chk("rdy_done", in_ready, 0);
      digest_ack = 1'b1;
      @(posedge clk); #1;
      digest_ack = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      chk("dv_ack", digest_valid, 0);
      chk("rdy_ack", in_ready, 1);
      chk("dig_keep", digest, exp_dig);
      chk("err_ok", err, 0);
      chk("starts", starts, exp_starts);
   endtask

   initial begin
      int cnt;
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk_rst();
      resetn = 1'b1;
      @(posedge clk); #1;

      // single byte, sequential hash bytes
      msg[0] = 8'h61;
      run_msg(1, 3, 1'b1, 1'b0, 1, 0);
      chk("dig_lo", digest[7:0], 8'h00);
      chk("dig_hi", digest[255:248], 8'h1f);

      // 20 bytes, padding after end, long digest hold
      for (int i = 0; i < 20; i++) msg[i] = 8'(i);
      run_msg(20, 32, 1'b0, 1'b0, 10, 0);

      // overflow: buffer full without in_last
      for (int i = 0; i < ML; i++) msg[i] = 8'($urandom);
      load_bytes(ML, 1'b0);
      chk("ovf_err", err, 1);
      chk("ovf_rdy", in_ready, 1);
      chk("ovf_nostart", starts, exp_starts);
      for (int i = 0; i < 7; i++) msg[i] = 8'($urandom);
      run_msg(7, 9, 1'b0, 1'b1, 2, 0);

      // timeout: core stays busy and silent
      for (int i = 0; i < 3; i++) msg[i] = 8'($urandom);
      load_bytes(3, 1'b1);
      exp_starts++;
      chk("tmo_start", core_start, 1);
      @(posedge clk); #1;
      core_busy  = 1'b1;
      core_valid = 1'b0;
      cnt = 0;
      while (!in_ready && cnt < 200) begin @(posedge clk); #1; cnt++; end
      chk("tmo_cycles", cnt, TO);
      chk("tmo_err", err, 1);
      chk("tmo_dv", digest_valid, 0);
      for (int i = 0; i < 4; i++) msg[i] = 8'($urandom);
      run_msg(4, 5, 1'b0, 1'b1, 1, 0);

      // asynchronous reset in the middle of collection
      for (int i = 0; i < 5; i++) msg[i] = 8'($urandom);
      run_msg(5, 5, 1'b0, 1'b1, 1, 10);
      #3 resetn = 1'b0;
      #1;
      chk_rst();
      core_valid = 1'b0;
      core_busy  = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) msg[i] = 8'($urandom);
      run_msg(3, 4, 1'b0, 1'b1, 3, 0);

      // random messages
      for (int m = 0; m < 8; m++) begin
         n = $urandom_range(1, ML);
         for (int i = 0; i < ML; i++) msg[i] = 8'($urandom);
         run_msg(n, n + $urandom_range(0, 4), 1'b0, 1'b1,
                 $urandom_range(1, 5), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
